// File: rtl/uart_cmd_host.sv
// uart_cmd_host: host-side initiator for the UART command protocol.
//   Takes one command on CMD_VALID/CMD_READY and sends it as back-to-back
//   UART frames (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU
//   without operands). It then collects the reply bytes from RX_IN and
//   presents them on RSP_* together with a one-cycle RSP_VALID pulse.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   CMD_VALID/READY     command handshake (READY high only when idle)
//   CMD_TYPE, CMD_P0-P2 command type and payload bytes
//   PAR_EN, PAR_TYP     parity enable / odd(1) or even(0), captured per command
//   TX_OUT, RX_IN       serial lines to / from the system
//   RSP_VALID, RSP_DATA reply pulse and {high,low} reply bytes
//   RSP_PAR_ERR/STP_ERR parity / stop errors ORed over all reply bytes
//   RSP_TIMEOUT         reply timed out (only with the optional feature)
//   BUSY                high whenever not idle
// Optional feature: define UART_HOST_TIMEOUT_EN to add the reply timeout
// counter (TIMEOUT_CYCLES cycles in RX_WAIT). Without it the host waits
// forever and RSP_TIMEOUT is tied low.
module uart_cmd_host #(
    parameter int CLKS_PER_BIT   = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [1:0]                CMD_TYPE,
    input  logic [DATA_WIDTH-1:0]     CMD_P0,
    input  logic [DATA_WIDTH-1:0]     CMD_P1,
    input  logic [DATA_WIDTH-1:0]     CMD_P2,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic                      TX_OUT,
    input  logic                      RX_IN,
    output logic                      RSP_VALID,
    output logic [2*DATA_WIDTH-1:0]   RSP_DATA,
    output logic                      RSP_PAR_ERR,
    output logic                      RSP_STP_ERR,
    output logic                      RSP_TIMEOUT,
    output logic                      BUSY
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 3);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'('hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'('hDD);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("uart_cmd_host: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_RX_FRAME, S_DONE} state_t;

    // Per-command settings frozen at the handshake.
    typedef struct packed {
        logic       par_en;
        logic       par_typ;
        logic [1:0] last_tx;   // index of the last byte to send
        logic [1:0] n_rx;      // reply bytes expected
    } cmd_t;

    state_t                           state;
    cmd_t                             cmd_q;
    logic [3:0][DATA_WIDTH-1:0]       tx_buf;
    logic [CW-1:0]                    cnt;
    logic [BW-1:0]                    bit_idx;
    logic [1:0]                       byte_idx;
    logic                             rx_s1, rx_s2, rx_prev;
    logic [DATA_WIDTH-1:0]            rx_shift;
    logic [2*DATA_WIDTH-1:0]          rx_acc;
    logic                             par_acc, stp_acc;
    logic [BW-1:0]                    last_bit;
    logic                             rx_fall;
    logic                             rx_par_exp;

`ifdef UART_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`else
    assign RSP_TIMEOUT = 1'b0;
`endif

    // Frame bit index: 0 start, 1..DATA_WIDTH data, then parity (if on), then stop.
    assign last_bit   = cmd_q.par_en ? BW'(DATA_WIDTH + 2) : BW'(DATA_WIDTH + 1);
    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_par_exp = (^rx_shift) ^ cmd_q.par_typ;

    function automatic logic frame_bit(input logic [DATA_WIDTH-1:0] b,
                                       input logic [BW-1:0] idx,
                                       input logic pe, input logic pt);
        logic [DATA_WIDTH-1:0] sh;
        sh = b >> (idx - 1'b1);
        if (idx == '0)                           frame_bit = 1'b0;
        else if (idx <= DATA_LAST)               frame_bit = sh[0];
        else if (idx == DATA_LAST + 1'b1 && pe)  frame_bit = (^b) ^ pt;
        else                                     frame_bit = 1'b1;
    endfunction

    // RX_IN is asynchronous: two flops before use, a third for edge detect.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX_IN;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            tx_buf      <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            rx_shift    <= '0;
            rx_acc      <= '0;
            par_acc     <= 1'b0;
            stp_acc     <= 1'b0;
            TX_OUT      <= 1'b1;
            CMD_READY   <= 1'b1;
            BUSY        <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= '0;
            RSP_PAR_ERR <= 1'b0;
            RSP_STP_ERR <= 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
            to_cnt      <= '0;
            RSP_TIMEOUT <= 1'b0;
`endif
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        cmd_q.par_en  <= PAR_EN;
                        cmd_q.par_typ <= PAR_TYP;
                        case (CMD_TYPE)
                            2'd0: begin
                                tx_buf <= {{DATA_WIDTH{1'b0}}, CMD_P1, CMD_P0, HDR_WR};
                                cmd_q.last_tx <= 2'd2; cmd_q.n_rx <= 2'd0;
                            end
                            2'd1: begin
                                tx_buf <= {{2*DATA_WIDTH{1'b0}}, CMD_P0, HDR_RD};
                                cmd_q.last_tx <= 2'd1; cmd_q.n_rx <= 2'd1;
                            end
                            2'd2: begin
                                tx_buf <= {CMD_P2, CMD_P1, CMD_P0, HDR_ALU};
                                cmd_q.last_tx <= 2'd3; cmd_q.n_rx <= 2'd2;
                            end
                            default: begin
                                tx_buf <= {{2*DATA_WIDTH{1'b0}}, CMD_P0, HDR_NOP};
                                cmd_q.last_tx <= 2'd1; cmd_q.n_rx <= 2'd2;
                            end
                        endcase
                        state       <= S_TX;
                        TX_OUT      <= 1'b0;     // first start bit right after the handshake
                        CMD_READY   <= 1'b0;
                        BUSY        <= 1'b1;
                        cnt         <= '0;
                        bit_idx     <= '0;
                        byte_idx    <= '0;
                        rx_acc      <= '0;
                        par_acc     <= 1'b0;
                        stp_acc     <= 1'b0;
                        RSP_PAR_ERR <= 1'b0;
                        RSP_STP_ERR <= 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
                        RSP_TIMEOUT <= 1'b0;
`endif
                    end
                end

                S_TX: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == last_bit) begin
                            bit_idx <= '0;
                            if (byte_idx == cmd_q.last_tx) begin
                                TX_OUT   <= 1'b1;
                                byte_idx <= '0;   // reused as reply byte index
                                if (cmd_q.n_rx == 2'd0) begin
                                    state     <= S_DONE;
                                    RSP_VALID <= 1'b1;
                                    RSP_DATA  <= '0;
                                end else begin
                                    state <= S_RX_WAIT;
`ifdef UART_HOST_TIMEOUT_EN
                                    to_cnt <= '0;
`endif
                                end
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                TX_OUT   <= 1'b0;   // next start bit, no idle gap
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TX_OUT  <= frame_bit(tx_buf[byte_idx], bit_idx + 1'b1,
                                                 cmd_q.par_en, cmd_q.par_typ);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RX_WAIT: begin
                    if (rx_fall) begin
                        state   <= S_RX_FRAME;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
`ifdef UART_HOST_TIMEOUT_EN
                    else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= S_DONE;
                        RSP_VALID   <= 1'b1;
                        RSP_DATA    <= rx_acc;
                        RSP_PAR_ERR <= par_acc;
                        RSP_STP_ERR <= stp_acc;
                        RSP_TIMEOUT <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                S_RX_FRAME: begin
                    // Start bit is checked half a bit in; later samples land mid-bit.
                    if ((bit_idx == '0) ? (cnt == HALF_LAST) : (cnt == BIT_LAST)) begin
                        cnt <= '0;
                        if (bit_idx == '0) begin
                            if (rx_s2) begin
                                state <= S_RX_WAIT;   // glitch, nothing counted
`ifdef UART_HOST_TIMEOUT_EN
                                to_cnt <= '0;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else if (bit_idx <= DATA_LAST) begin
                            rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
                            bit_idx  <= bit_idx + 1'b1;
                        end else if (bit_idx == last_bit) begin
                            stp_acc <= stp_acc | ~rx_s2;
                            if (byte_idx == 2'd0) rx_acc[DATA_WIDTH-1:0]            <= rx_shift;
                            else                  rx_acc[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_shift;
                            if (byte_idx + 2'd1 == cmd_q.n_rx) begin
                                state       <= S_DONE;
                                RSP_VALID   <= 1'b1;
                                RSP_DATA    <= (byte_idx == 2'd0) ?
                                               {{DATA_WIDTH{1'b0}}, rx_shift} :
                                               {rx_shift, rx_acc[DATA_WIDTH-1:0]};
                                RSP_PAR_ERR <= par_acc;
                                RSP_STP_ERR <= stp_acc | ~rx_s2;
                            end else begin
                                state    <= S_RX_WAIT;
                                byte_idx <= byte_idx + 1'b1;
`ifdef UART_HOST_TIMEOUT_EN
                                to_cnt   <= '0;
`endif
                            end
                        end else begin
                            // parity slot
                            if (rx_s2 != rx_par_exp) par_acc <= 1'b1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    CMD_READY <= 1'b1;
                    BUSY      <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
